// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/pause/clear keys drive a MM:SS BCD timer shown on a 4-digit scanned display.
// Latency: key event acts 2 edges after the key rises; display follows time and scan updates on the same edge.
// No backpressure: keys are sampled levels, outputs are free-running registered drives.
module stopwatch_ctrl #(
  parameter logic [25:0] CNT_MAX  = 26'd50_000_000,
  parameter logic [15:0] SCAN_MAX = 16'd50_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start_pause,
  input  logic       clear,
  output logic [3:0] sel,
  output logic [7:0] seg,
  output logic       running,
  output logic       sec_tick
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // key history: cur is the registered key level, prev is the level one cycle earlier
  logic        sp_cur;
  logic        sp_prev;
  logic        clr_cur;
  logic        clr_prev;
  logic        sp_evt;
  logic        clr_evt;

  logic [25:0] cnt0;
  logic [25:0] cnt0_nxt;
  logic        tick_nxt;

  logic [3:0]  s_lo;
  logic [3:0]  s_hi;
  logic [3:0]  m_lo;
  logic [3:0]  m_hi;
  logic [3:0]  s_lo_nxt;
  logic [3:0]  s_hi_nxt;
  logic [3:0]  m_lo_nxt;
  logic [3:0]  m_hi_nxt;

  logic [15:0] scan_cnt;
  logic [15:0] scan_nxt;
  logic [1:0]  idx;
  logic [1:0]  idx_nxt;

  logic [3:0]  digit_nxt;
  logic [3:0]  sel_nxt;
  logic [7:0]  seg_nxt;

  // common-anode 7-segment patterns {dp,g,f,e,d,c,b,a}; unknown codes blank the digit
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    return code;
  endfunction

  // a key event is a 0->1 step of the registered level, so a held key fires once
  assign sp_evt  = sp_cur  & ~sp_prev;
  assign clr_evt = clr_cur & ~clr_prev;

  // sample the debounced keys once and keep one cycle of history for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sp_cur   <= 1'b0;
      sp_prev  <= 1'b0;
      clr_cur  <= 1'b0;
      clr_prev <= 1'b0;
    end else begin
      sp_cur   <= start_pause;
      sp_prev  <= sp_cur;
      clr_cur  <= clear;
      clr_prev <= clr_cur;
    end
  end

  // next FSM state: clear wins over start_pause when both fire together
  always_comb begin
    state_nxt = state;
    if (clr_evt) begin
      state_nxt = IDLE;
    end else if (sp_evt) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // prescaler and BCD time: count only in RUN, hold in PAUSE, zero in IDLE or on clear
  always_comb begin
    cnt0_nxt = cnt0;
    tick_nxt = 1'b0;
    s_lo_nxt = s_lo;
    s_hi_nxt = s_hi;
    m_lo_nxt = m_lo;
    m_hi_nxt = m_hi;
    if (clr_evt) begin
      cnt0_nxt = 26'd0;
      s_lo_nxt = 4'd0;
      s_hi_nxt = 4'd0;
      m_lo_nxt = 4'd0;
      m_hi_nxt = 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (cnt0 == CNT_MAX - 26'd1) begin
            cnt0_nxt = 26'd0;
            tick_nxt = 1'b1;
            // full carry ripple in one cycle; 59:59 rolls silently to 00:00
            if (s_lo == 4'd9) begin
              s_lo_nxt = 4'd0;
              if (s_hi == 4'd5) begin
                s_hi_nxt = 4'd0;
                if (m_lo == 4'd9) begin
                  m_lo_nxt = 4'd0;
                  if (m_hi == 4'd5) begin
                    m_hi_nxt = 4'd0;
                  end else begin
                    m_hi_nxt = m_hi + 4'd1;
                  end
                end else begin
                  m_lo_nxt = m_lo + 4'd1;
                end
              end else begin
                s_hi_nxt = s_hi + 4'd1;
              end
            end else begin
              s_lo_nxt = s_lo + 4'd1;
            end
          end else begin
            cnt0_nxt = cnt0 + 26'd1;
          end
        end
        PAUSE: begin
          cnt0_nxt = cnt0;
        end
        default: begin
          cnt0_nxt = 26'd0;
        end
      endcase
    end
  end

  // digit scan runs in every state; index steps once per scan period
  always_comb begin
    scan_nxt = scan_cnt + 16'd1;
    idx_nxt  = idx;
    if (scan_cnt == SCAN_MAX - 16'd1) begin
      scan_nxt = 16'd0;
      idx_nxt  = idx + 2'd1;
    end
  end

  // display decode from next-cycle index and time so sel/seg land with the update, not after it
  always_comb begin
    sel_nxt   = 4'b1110;
    digit_nxt = s_lo_nxt;
    case (idx_nxt)
      2'd0: begin
        sel_nxt   = 4'b1110;
        digit_nxt = s_lo_nxt;
      end
      2'd1: begin
        sel_nxt   = 4'b1101;
        digit_nxt = s_hi_nxt;
      end
      2'd2: begin
        sel_nxt   = 4'b1011;
        digit_nxt = m_lo_nxt;
      end
      default: begin
        sel_nxt   = 4'b0111;
        digit_nxt = m_hi_nxt;
      end
    endcase
    // decimal point separates minutes from seconds, so it sits on the m_lo digit
    seg_nxt = seg_code(digit_nxt) & ((idx_nxt == 2'd2) ? 8'h7F : 8'hFF);
  end

  // single state register for FSM, counters, time and all registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      running  <= 1'b0;
      sec_tick <= 1'b0;
      cnt0     <= 26'd0;
      s_lo     <= 4'd0;
      s_hi     <= 4'd0;
      m_lo     <= 4'd0;
      m_hi     <= 4'd0;
      scan_cnt <= 16'd0;
      idx      <= 2'd0;
      sel      <= 4'b1110;
      seg      <= 8'hC0;
    end else begin
      state    <= state_nxt;
      running  <= (state_nxt == RUN);
      sec_tick <= tick_nxt;
      cnt0     <= cnt0_nxt;
      s_lo     <= s_lo_nxt;
      s_hi     <= s_hi_nxt;
      m_lo     <= m_lo_nxt;
      m_hi     <= m_hi_nxt;
      scan_cnt <= scan_nxt;
      idx      <= idx_nxt;
      sel      <= sel_nxt;
      seg      <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CNT_MAX=10, SCAN_MAX=4.
// Stimulus pushes hand-computed expectations (cycle, kind, value) and expected tick cycles;
// negedge monitors pop and compare, plus a continuous scan-order / decimal-point monitor.
module tb_stopwatch_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       start_pause;
  logic       clear;
  logic [3:0] sel;
  logic [7:0] seg;
  logic       running;
  logic       sec_tick;

  stopwatch_ctrl #(
    .CNT_MAX (26'd10),
    .SCAN_MAX(16'd4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start_pause(start_pause),
    .clear      (clear),
    .sel        (sel),
    .seg        (seg),
    .running    (running),
    .sec_tick   (sec_tick)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  localparam int K_RST  = 0;
  localparam int K_RUN  = 1;
  localparam int K_DISP = 2;

  int          exp_at[$];
  int          exp_kind[$];
  logic [15:0] exp_val[$];
  string       exp_name[$];
  int          tick_q[$];

  function automatic logic [7:0] code(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // expected seg for the digit currently selected, time given as BCD mm:ss
  function automatic logic [7:0] exp_seg(input logic [3:0] s, input logic [15:0] t);
    case (s)
      4'b1110: return code(t[3:0]);
      4'b1101: return code(t[7:4]);
      4'b1011: return code(t[11:8]) & 8'h7F;
      4'b0111: return code(t[15:12]);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] next_sel(input logic [3:0] s);
    case (s)
      4'b1110: return 4'b1101;
      4'b1101: return 4'b1011;
      4'b1011: return 4'b0111;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic expect_at(input int at, input int kind, input logic [15:0] val, input string name);
    exp_at.push_back(at);
    exp_kind.push_back(kind);
    exp_val.push_back(val);
    exp_name.push_back(name);
  endtask

  // four samples 4 cycles apart land on four different digits whatever the scan phase
  task automatic expect_disp4(input int at, input logic [15:0] t, input string name);
    for (int i = 0; i < 4; i++) expect_at(at + 4 * i, K_DISP, t, name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) step(1);
  endtask

  // scoreboard monitor: due expectations and expected sec_tick cycles
  always @(negedge sys_clk) begin
    int i;
    logic [7:0] want;
    i = 0;
    while (i < exp_at.size()) begin
      if (exp_at[i] <= cyc) begin
        checks++;
        case (exp_kind[i])
          K_RST: begin
            if (sel !== 4'b1110 || seg !== 8'hC0 || running !== 1'b0 || sec_tick !== 1'b0) begin
              errors++;
              $display("FAIL %s @%0d: sel=%b seg=%h running=%b sec_tick=%b, need sel=1110 seg=c0 running=0 sec_tick=0",
                       exp_name[i], cyc, sel, seg, running, sec_tick);
            end
          end
          K_RUN: begin
            if (running !== exp_val[i][0]) begin
              errors++;
              $display("FAIL %s @%0d: running=%b, need %b", exp_name[i], cyc, running, exp_val[i][0]);
            end
          end
          default: begin
            want = exp_seg(sel, exp_val[i]);
            if (seg !== want) begin
              errors++;
              $display("FAIL %s @%0d: sel=%b seg=%h, need seg=%h for time %h",
                       exp_name[i], cyc, sel, seg, want, exp_val[i]);
            end
          end
        endcase
        exp_at.delete(i);
        exp_kind.delete(i);
        exp_val.delete(i);
        exp_name.delete(i);
      end else begin
        i++;
      end
    end
    while (tick_q.size() > 0 && tick_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL tick_missing @%0d: sec_tick=0, need 1 at cycle %0d", cyc, tick_q[0]);
      void'(tick_q.pop_front());
    end
    if (sec_tick === 1'b1) begin
      checks++;
      if (tick_q.size() > 0 && tick_q[0] == cyc) begin
        void'(tick_q.pop_front());
      end else begin
        errors++;
        $display("FAIL tick_unexpected @%0d: sec_tick=1, need 0", cyc);
      end
    end
  end

  // scan monitor: digit order, 4-cycle dwell, decimal point only on sel=1011
  logic [3:0] prev_sel;
  int         run_len = 0;
  bit         have_prev = 1'b0;
  bit         seq_ok = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      have_prev = 1'b0;
      seq_ok    = 1'b0;
    end else begin
      checks++;
      if (seg[7] !== (sel != 4'b1011)) begin
        errors++;
        $display("FAIL scan_dp @%0d: sel=%b seg=%h, need seg[7]=%b", cyc, sel, seg, (sel != 4'b1011));
      end
      if (!have_prev) begin
        have_prev = 1'b1;
        prev_sel  = sel;
        run_len   = 1;
      end else if (sel == prev_sel) begin
        run_len++;
        if (run_len == 5) begin
          checks++;
          errors++;
          $display("FAIL scan_stuck @%0d: sel=%b held 5 cycles, need 4", cyc, sel);
        end
      end else begin
        checks++;
        if (sel !== next_sel(prev_sel)) begin
          errors++;
          $display("FAIL scan_order @%0d: sel=%b after %b, need %b", cyc, sel, prev_sel, next_sel(prev_sel));
        end
        if (seq_ok) begin
          checks++;
          if (run_len != 4) begin
            errors++;
            $display("FAIL scan_dwell @%0d: sel=%b lasted %0d cycles, need 4", cyc, prev_sel, run_len);
          end
        end
        seq_ok   = 1'b1;
        prev_sel = sel;
        run_len  = 1;
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: cycle %0d reached time limit, need completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, c, d, w, e, f, g, h;
    sys_rst_n   = 1'b0;
    start_pause = 1'b0;
    clear       = 1'b0;
    step(1);
    expect_at(cyc, K_RST, 16'h0, "reset_hold");
    step(2);
    sys_rst_n = 1'b1;
    expect_at(cyc + 2, K_RUN, 16'h0, "idle_running");
    expect_disp4(cyc + 2, 16'h0000, "idle_display");
    goto_cyc(30);

    // run from idle with a held key: one event only
    k = cyc;
    start_pause = 1'b1;
    expect_at(k + 1, K_RUN, 16'h0, "run_early");
    expect_at(k + 2, K_RUN, 16'h1, "run_entry");
    expect_at(k + 40, K_RUN, 16'h1, "held_key_once");
    for (int n = 0; n < 600; n++) tick_q.push_back(k + 12 + 10 * n);
    goto_cyc(k + 50);
    start_pause = 1'b0;
    expect_at(k + 6002, K_DISP, 16'h1000, "ten_min_same_edge");

    // pause with cnt0 held at 5
    c = k + 6005;
    goto_cyc(c);
    start_pause = 1'b1;
    expect_at(c + 1, K_RUN, 16'h1, "pause_early");
    expect_at(c + 2, K_RUN, 16'h0, "pause_entry");
    expect_disp4(c + 4, 16'h1000, "pause_display");
    step(3);
    start_pause = 1'b0;

    // resume: next tick after exactly 5 RUN cycles, then run on to the 59:59 wrap
    d = c + 40;
    goto_cyc(d);
    start_pause = 1'b1;
    expect_at(d + 1, K_RUN, 16'h0, "resume_early");
    expect_at(d + 2, K_RUN, 16'h1, "resume_entry");
    for (int n = 0; n <= 3000; n++) tick_q.push_back(d + 7 + 10 * n);
    step(3);
    start_pause = 1'b0;
    w = d + 29997;
    expect_at(w - 10, K_DISP, 16'h5959, "pre_wrap");
    expect_at(w - 6, K_DISP, 16'h5959, "pre_wrap");
    expect_at(w - 2, K_DISP, 16'h5959, "pre_wrap");
    expect_at(w, K_DISP, 16'h0000, "wrap_display");
    expect_at(w + 4, K_DISP, 16'h0000, "wrap_display");
    expect_at(w + 8, K_DISP, 16'h0000, "wrap_display");
    expect_at(w, K_RUN, 16'h1, "wrap_running");
    expect_at(w + 5, K_RUN, 16'h1, "wrap_running");
    expect_at(w + 12, K_DISP, 16'h0001, "after_wrap");

    // clear and start_pause together in RUN: clear wins
    e = w + 13;
    goto_cyc(e);
    start_pause = 1'b1;
    clear       = 1'b1;
    expect_at(e + 1, K_RUN, 16'h1, "both_early");
    expect_at(e + 2, K_RUN, 16'h0, "both_idle");
    expect_disp4(e + 2, 16'h0000, "both_display");
    step(3);
    start_pause = 1'b0;
    clear       = 1'b0;

    // start_pause alone restarts from 00:00 with a fresh prescaler
    f = e + 20;
    goto_cyc(f);
    start_pause = 1'b1;
    expect_at(f + 1, K_RUN, 16'h0, "restart_early");
    expect_at(f + 2, K_RUN, 16'h1, "restart_entry");
    tick_q.push_back(f + 12);
    expect_at(f + 13, K_DISP, 16'h0001, "restart_count");
    step(3);
    start_pause = 1'b0;

    // asynchronous reset mid-run, between clock edges
    g = f + 15;
    goto_cyc(g);
    #1;
    sys_rst_n = 1'b0;
    expect_at(g, K_RST, 16'h0, "reset_mid_run");
    step(3);
    sys_rst_n = 1'b1;
    expect_at(g + 5, K_RUN, 16'h0, "post_reset_idle");
    expect_at(g + 30, K_RUN, 16'h0, "post_reset_idle");
    expect_disp4(g + 10, 16'h0000, "post_reset_display");

    h = g + 50;
    goto_cyc(h);
    start_pause = 1'b1;
    expect_at(h + 1, K_RUN, 16'h0, "post_reset_early");
    expect_at(h + 2, K_RUN, 16'h1, "post_reset_start");
    tick_q.push_back(h + 12);
    step(3);
    start_pause = 1'b0;
    goto_cyc(h + 20);

    for (int n = 0; n < 100 && (exp_at.size() > 0 || tick_q.size() > 0); n++) step(1);
    for (int i = 0; i < exp_at.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never evaluated, need it reached", exp_name[i], exp_at[i]);
    end
    for (int i = 0; i < tick_q.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL tick_pending: tick for cycle %0d never seen, need sec_tick=1", tick_q[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
